// File: rtl/tpu_package.sv
// Shared types for the instruction queue decoder: raw field positions, opcodes,
// MAC operation codes and the decoded record carried through the queue.
package tpu_package;

    localparam int DIM_W  = 8;
    localparam int ADDR_W = 12;

    localparam int OPC_LSB  = 0;
    localparam int OPC_MSB  = 3;
    localparam int V_LSB    = 4;
    localparam int U_LSB    = 12;
    localparam int ITER_LSB = 20;
    localparam int RD_LSB   = 28;
    localparam int WR_LSB   = 40;
    localparam int FIELD_TOP = 51;

    typedef enum logic [3:0] {
        OPC_NOP        = 4'h0,
        OPC_MATMUL     = 4'h1,
        OPC_MATMUL_ACC = 4'h2,
        OPC_LOAD_W     = 4'h3
    } opcode_e;

    localparam logic [2:0] MAC_LOAD_W     = 3'b001;
    localparam logic [2:0] MAC_MATMUL     = 3'b010;
    localparam logic [2:0] MAC_MATMUL_ACC = 3'b011;

    // What the decode stage currently holds; only KIND_LEGAL records reach the queue.
    typedef enum logic [1:0] {
        KIND_EMPTY   = 2'd0,
        KIND_LEGAL   = 2'd1,
        KIND_NOP     = 2'd2,
        KIND_ILLEGAL = 2'd3
    } stage_kind_e;

    typedef struct packed {
        logic [2:0]        mac_op;
        logic [DIM_W-1:0]  v_dim;
        logic [DIM_W-1:0]  u_dim;
        logic [DIM_W-1:0]  iter_dim;
        logic [DIM_W-1:0]  v_dim1;
        logic [DIM_W-1:0]  u_dim1;
        logic [DIM_W-1:0]  iter_dim1;
        logic [ADDR_W-1:0] rd_addr;
        logic [ADDR_W-1:0] wr_addr;
    } decode_registers_t;

endpackage

// File: rtl/decoded_instr_fifo.sv
// Circular queue of decoded records: DEPTH entries, wrap-around pointers,
// explicit occupancy count, synchronous flush.
module decoded_instr_fifo
    import tpu_package::*;
#(
    parameter int  DEPTH = 16,
    parameter type T     = decode_registers_t,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             wr_en,
    input  T                 wr_data,
    input  logic             rd_en,
    output T                 rd_data,
    output logic             rd_valid,
    output logic [CNT_W-1:0] count
);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             do_wr;
    logic             do_pop;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign do_pop = rd_en & ~empty;
    // A write into a full queue is only legal when the head leaves the same cycle.
    assign do_wr  = wr_en & (~full | do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr)  wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_wr, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr && !flush_i) mem[wr_ptr] <= wr_data;
    end

    // Storage is not reset, so the head is masked whenever the queue is empty.
    assign rd_valid = ~empty;
    assign rd_data  = empty ? T'('0) : mem[rd_ptr];

endmodule

// File: rtl/instruction_queue_decoder.sv
// Accepts raw host instructions, decodes them in one registered stage and queues
// legal records for the MAC/sequencer; NOPs and illegal encodings are dropped.
module instruction_queue_decoder
    import tpu_package::*;
#(
    parameter int  INSTR_W   = 64,
    parameter int  DEPTH     = 16,
    parameter int  DIM_W     = tpu_package::DIM_W,
    parameter int  ADDR_W    = tpu_package::ADDR_W,
    parameter int  AFULL_LVL = DEPTH - 2,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [INSTR_W-1:0] instr_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output decode_registers_t decoded_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              afull_o,
    output logic              err_illegal_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never depends on ready, and in_ready_o never depends on out_ready_i.

    opcode_e           opcode;
    logic [DIM_W-1:0]  f_v;
    logic [DIM_W-1:0]  f_u;
    logic [DIM_W-1:0]  f_iter;
    logic [ADDR_W-1:0] f_rd;
    logic [ADDR_W-1:0] f_wr;

    decode_registers_t next_rec;
    stage_kind_e       next_kind;
    decode_registers_t stage_rec;
    stage_kind_e       stage_kind;

    logic             push;
    logic             stage_occ;
    logic [CNT_W:0]   reserved;
    logic [CNT_W-1:0] count;

    assign opcode = opcode_e'(instr_i[OPC_LSB +: 4]);
    assign f_v    = instr_i[V_LSB    +: DIM_W];
    assign f_u    = instr_i[U_LSB    +: DIM_W];
    assign f_iter = instr_i[ITER_LSB +: DIM_W];
    assign f_rd   = instr_i[RD_LSB   +: ADDR_W];
    assign f_wr   = instr_i[WR_LSB   +: ADDR_W];

    if (INSTR_W > FIELD_TOP + 1) begin : g_upper
        logic unused_upper;
        assign unused_upper = ^instr_i[INSTR_W-1:FIELD_TOP+1];
    end

    always_comb begin
        next_kind          = KIND_ILLEGAL;
        next_rec           = '0;
        next_rec.v_dim     = f_v;
        next_rec.u_dim     = f_u;
        next_rec.iter_dim  = f_iter;
        next_rec.v_dim1    = f_v - DIM_W'(1);
        next_rec.u_dim1    = f_u - DIM_W'(1);
        next_rec.iter_dim1 = f_iter - DIM_W'(1);
        next_rec.rd_addr   = f_rd;
        next_rec.wr_addr   = f_wr;
        case (opcode)
            OPC_NOP: next_kind = KIND_NOP;
            OPC_MATMUL, OPC_MATMUL_ACC: begin
                next_rec.mac_op = (opcode == OPC_MATMUL) ? MAC_MATMUL : MAC_MATMUL_ACC;
                if (f_v != '0 && f_u != '0 && f_iter != '0) next_kind = KIND_LEGAL;
            end
            OPC_LOAD_W: begin
                // Weight loads carry no iteration count or write-back address;
                // the forced-zero ITER still yields dim-1 = all ones.
                next_rec.mac_op    = MAC_LOAD_W;
                next_rec.iter_dim  = '0;
                next_rec.iter_dim1 = '1;
                next_rec.wr_addr   = '0;
                if (f_v != '0 && f_u != '0) next_kind = KIND_LEGAL;
            end
            default: next_kind = KIND_ILLEGAL;
        endcase
    end

    assign stage_occ  = (stage_kind != KIND_EMPTY);
    assign reserved   = {1'b0, count} + {{CNT_W{1'b0}}, stage_occ};
    assign in_ready_o = flush_i | (reserved < (CNT_W+1)'(DEPTH));
    assign push       = in_valid_i & in_ready_o & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_kind <= KIND_EMPTY;
            stage_rec  <= '0;
        end else if (flush_i) begin
            stage_kind <= KIND_EMPTY;
        end else if (push) begin
            stage_kind <= next_kind;
            stage_rec  <= next_rec;
        end else begin
            stage_kind <= KIND_EMPTY;
        end
    end

    assign err_illegal_o = (stage_kind == KIND_ILLEGAL) & ~flush_i;

    decoded_instr_fifo #(
        .DEPTH (DEPTH),
        .T     (decode_registers_t)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .flush_i  (flush_i),
        .wr_en    (stage_kind == KIND_LEGAL),
        .wr_data  (stage_rec),
        .rd_en    (out_ready_i),
        .rd_data  (decoded_o),
        .rd_valid (out_valid_o),
        .count    (count)
    );

    assign count_o = count;
    assign afull_o = (count >= CNT_W'(AFULL_LVL));

endmodule

// File: tb/tb_instruction_queue_decoder.sv
// Randomised bench for instruction_queue_decoder against a queue-based reference
// model, plus literal expectations on directed sequences.
module tb_instruction_queue_decoder;
    import tpu_package::*;

    localparam int DEPTH = 16;
    localparam int REC_W = $bits(decode_registers_t);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [63:0]       instr;
    logic              out_valid;
    logic              out_ready;
    decode_registers_t decoded;
    logic [4:0]        count;
    logic              afull;
    logic              err;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Reference model: queued records plus what the decode stage holds
    // (0 empty, 1 legal, 2 nop, 3 illegal).
    logic [REC_W-1:0] exp_q[$];
    int               st_kind = 0;
    logic [REC_W-1:0] st_rec = '0;

    instruction_queue_decoder #(.INSTR_W(64), .DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .flush_i       (flush),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .instr_i       (instr),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .decoded_o     (decoded),
        .count_o       (count),
        .afull_o       (afull),
        .err_illegal_o (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk(input int op, input int v, input int u, input int it,
                                       input int rd, input int wr);
        logic [63:0] w;
        w = 64'(op & 15) | (64'(v & 255) << 4) | (64'(u & 255) << 12) | (64'(it & 255) << 20)
          | (64'(rd & 4095) << 28) | (64'(wr & 4095) << 40);
        w[63:52] = 12'($urandom_range(0, 4095));
        return w;
    endfunction

    function automatic int rand_dim(input bit nonzero);
        if (!nonzero && $urandom_range(0, 7) == 0) return 0;
        return $urandom_range(1, 255);
    endfunction

    function automatic logic [63:0] rand_instr(input bit legal_only);
        int op;
        op = legal_only ? $urandom_range(1, 3) : $urandom_range(0, 15);
        return mk(op, rand_dim(legal_only), rand_dim(legal_only), rand_dim(legal_only),
                  $urandom_range(0, 4095), $urandom_range(0, 4095));
    endfunction

    function automatic void model_decode(input logic [63:0] ins, output int kind,
                                         output logic [REC_W-1:0] rec);
        decode_registers_t r;
        int op, v, u, it, rd, wr;
        op = int'(ins[3:0]);   v  = int'(ins[11:4]);  u  = int'(ins[19:12]);
        it = int'(ins[27:20]); rd = int'(ins[39:28]); wr = int'(ins[51:40]);
        r = '0;
        if (op == 0) kind = 2;
        else if (op > 3) kind = 3;
        else begin
            kind = (v != 0 && u != 0 && (op == 3 || it != 0)) ? 1 : 3;
            if (op == 3) begin it = 0; wr = 0; end
            r.mac_op    = (op == 1) ? 3'b010 : (op == 2) ? 3'b011 : 3'b001;
            r.v_dim     = 8'(v);     r.u_dim  = 8'(u);     r.iter_dim  = 8'(it);
            r.v_dim1    = 8'(v - 1); r.u_dim1 = 8'(u - 1); r.iter_dim1 = 8'(it - 1);
            r.rd_addr   = 12'(rd);   r.wr_addr = 12'(wr);
        end
        rec = r;
    endfunction

    always @(negedge rst_n) begin
        exp_q.delete();
        st_kind = 0;
    end

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            bit ready_p, push_p, pop_p;
            ready_p = flush || (exp_q.size() + (st_kind != 0 ? 1 : 0) < DEPTH);
            push_p  = in_valid && ready_p;
            pop_p   = out_ready && exp_q.size() > 0;
            if (flush) begin
                exp_q.delete();
                st_kind = 0;
            end else begin
                if (pop_p) void'(exp_q.pop_front());
                if (st_kind == 1) exp_q.push_back(st_rec);
                if (push_p) model_decode(instr, st_kind, st_rec);
                else st_kind = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            int n, occ;
            n   = exp_q.size();
            occ = (st_kind != 0) ? 1 : 0;
            check("in_ready", in_ready, flush || (n + occ < DEPTH));
            check("out_valid", out_valid, n > 0);
            check("decoded", decoded, n > 0 ? exp_q[0] : '0);
            check("count", count, n);
            check("afull", afull, n >= DEPTH - 2);
            check("err_illegal", err, st_kind == 3 && !flush);
        end
    end

    task automatic drive(input bit fl, input bit v, input logic [63:0] ins, input bit rdy);
        @(posedge clk);
        #1;
        flush = fl; in_valid = v; instr = ins; out_ready = rdy;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_afull"}, afull, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_decoded"}, decoded, 0);
    endtask

    task automatic check_matmul_head(input string tag);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_mac_op"}, decoded.mac_op, 3'b010);
        check({tag, "_v_dim1"}, decoded.v_dim1, 3);
        check({tag, "_u_dim1"}, decoded.u_dim1, 7);
        check({tag, "_iter_dim1"}, decoded.iter_dim1, 1);
        check({tag, "_rd"}, decoded.rd_addr, 12'h010);
        check({tag, "_wr"}, decoded.wr_addr, 12'h200);
        check({tag, "_count"}, count, 1);
        check({tag, "_model_count"}, exp_q.size(), 1);
    endtask

    logic [63:0] mm;

    initial begin
        rst_n = 1'b1; flush = 0; in_valid = 0; instr = '0; out_ready = 0;
        #1 rst_n = 1'b0;
        #2 check_en = 1'b1;
        check_reset_values("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single MATMUL: visible at N+2, not at N+1.
        mm = mk(1, 4, 8, 2, 12'h010, 12'h200);
        drive(0, 1, mm, 0);
        drive(0, 0, '0, 0);
        @(negedge clk);
        check("mm_n1_valid", out_valid, 0);
        @(negedge clk);
        check_matmul_head("mm");
        drive(0, 0, '0, 1);

        // Fill with out_ready low until the reservation closes the input.
        repeat (20) drive(0, 1, rand_instr(1), 0);
        drive(0, 0, '0, 0);
        @(negedge clk);
        check("full_count", count, 16);
        check("full_in_ready", in_ready, 0);
        check("full_afull", afull, 1);

        // Sustained push and pop from a full queue, then drain.
        repeat (40) drive(0, 1'($urandom_range(0, 1)), rand_instr(1), 1);
        repeat (20) drive(0, 0, '0, 1);
        @(negedge clk);
        check("drained_count", count, 0);

        // Illegal opcode pulses for one cycle.
        drive(0, 1, mk(7, 4, 8, 2, 1, 2), 1);
        drive(0, 0, '0, 1);
        @(negedge clk);
        check("op7_err_pulse", err, 1);
        @(negedge clk);
        check("op7_err_clear", err, 0);
        check("op7_count", count, 0);
        drive(0, 1, mk(1, 4, 0, 2, 1, 2), 1);
        drive(0, 1, mk(0, 4, 8, 2, 1, 2), 1);
        drive(0, 0, '0, 1);
        @(negedge clk);
        check("nop_no_err", err, 0);

        // Flush with eight queued entries and a concurrent push.
        repeat (8) drive(0, 1, rand_instr(1), 0);
        repeat (2) drive(0, 0, '0, 0);
        @(negedge clk);
        check("pre_flush_count", count, 8);
        drive(1, 1, rand_instr(1), 0);
        drive(0, 0, '0, 0);
        @(negedge clk);
        check("flush_count", count, 0);
        check("flush_valid", out_valid, 0);
        drive(0, 1, mm, 0);
        drive(0, 0, '0, 0);
        @(negedge clk);
        check("post_flush_n1", out_valid, 0);
        @(negedge clk);
        check_matmul_head("post_flush");

        // Fully random traffic.
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, rand_instr(0),
                  $urandom_range(0, 9) < 6);

        // Asynchronous reset in the middle of a burst.
        repeat (12) drive(0, 1, rand_instr(1), $urandom_range(0, 3) == 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        flush = 0; in_valid = 0; out_ready = 0;
        #1 check_reset_values("async_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(0, 1, mm, 0);
        drive(0, 0, '0, 0);
        @(negedge clk);
        @(negedge clk);
        check_matmul_head("after_reset");

        for (int i = 0; i < 200; i++)
            drive(0, $urandom_range(0, 9) < 8, rand_instr(0), $urandom_range(0, 9) < 4);
        repeat (20) drive(0, 0, '0, 1);
        @(negedge clk);
        check_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
